// File: rtl/mem_banked_be.sv
// mem_banked_be: single-port memory with per-byte write enables. It clears itself to INIT_VAL after reset and returns reads through a registered path.
// Optional macro PARITY_EN adds per-byte even-parity storage and a parity check on every read.
module mem_banked_be #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      DEPTH      = 64,
  parameter int unsigned      ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned      BE_WIDTH   = WIDTH / 8,
  parameter logic [WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [BE_WIDTH-1:0]   byte_en_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  output logic                  err_o,
  output logic                  init_done_o
);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]      MEM [DEPTH];
  logic                  accept;
  logic                  in_range;
  logic                  wr_ok;
  logic                  par_bad;
  logic [ADDR_WIDTH-1:0] idx;

  assign accept   = valid_i && ready_o;
  // Widened compare so a power-of-two DEPTH does not truncate to zero.
  assign in_range = 32'(addr_i) < DEPTH;
  assign idx      = in_range ? addr_i : '0;
  assign wr_ok    = accept && wr_rd_i && in_range;

  // Storage has no reset; the INIT state overwrites it word by word instead.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      MEM[cnt] <= INIT_VAL;
    end else if (wr_ok) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (byte_en_i[b]) MEM[addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

`ifdef PARITY_EN
  logic [BE_WIDTH-1:0] PAR [DEPTH];

  function automatic logic [BE_WIDTH-1:0] byte_par(input logic [WIDTH-1:0] w);
    logic [BE_WIDTH-1:0] p;
    p = '0;
    for (int unsigned b = 0; b < BE_WIDTH; b++) p[b] = ^w[8*b +: 8];
    return p;
  endfunction

  assign par_bad = (byte_par(MEM[idx]) != PAR[idx]);

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      PAR[cnt] <= byte_par(INIT_VAL);
    end else if (wr_ok) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (byte_en_i[b]) PAR[addr_i][b] <= ^wr_data_i[8*b +: 8];
      end
    end
  end
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_INIT;
      cnt         <= '0;
      ready_o     <= 1'b0;
      init_done_o <= 1'b0;
      rd_data_o   <= '0;
      rd_valid_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        S_INIT: begin
          if (cnt == CNT_LAST) begin
            state       <= S_IDLE;
            ready_o     <= 1'b1;
            init_done_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            if (!in_range) err_o <= 1'b1;
            if (!wr_rd_i) begin
              rd_valid_o <= 1'b1;
              rd_data_o  <= in_range ? MEM[idx] : '0;
              if (in_range && par_bad) err_o <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_banked_be.sv
// Randomized self-checking bench for mem_banked_be: a DEPTH=64 instance against an array model, and a DEPTH=48 instance for range errors.
module tb_mem_banked_be;

`ifdef PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  addr_i = '0;
  logic        wr_rd_i = 1'b0, valid_i = 1'b0;
  logic [15:0] wr_data_i = '0;
  logic [1:0]  byte_en_i = '0;
  logic        ready_o, rd_valid_o, err_o, init_done_o;
  logic [15:0] rd_data_o;

  logic [5:0]  a48 = '0;
  logic        wr48 = 1'b0, v48 = 1'b0;
  logic [15:0] d48 = '0;
  logic [1:0]  be48 = '0;
  logic        ready48, rv48, err48, done48;
  logic [15:0] rd48;

  mem_banked_be dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .wr_rd_i(wr_rd_i), .wr_data_i(wr_data_i),
    .byte_en_i(byte_en_i), .valid_i(valid_i), .ready_o(ready_o), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .err_o(err_o), .init_done_o(init_done_o)
  );

  mem_banked_be #(.DEPTH(48)) dut48 (
    .clk(clk), .rst(rst), .addr_i(a48), .wr_rd_i(wr48), .wr_data_i(d48),
    .byte_en_i(be48), .valid_i(v48), .ready_o(ready48), .rd_data_o(rd48),
    .rd_valid_o(rv48), .err_o(err48), .init_done_o(done48)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: word array, plus a mask of bytes whose stored parity was broken behind the memory's back.
  logic [15:0] model   [64];
  logic [1:0]  badmask [64];
  logic        exp_rv  = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_rd  = '0;

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      model[i]   = '0;
      badmask[i] = '0;
    end
    exp_rv = 1'b0; exp_err = 1'b0; exp_rd = '0;
  endtask

  // Checks the outcome of the previous cycle's request, then drives the next one.
  task automatic step(input logic v, input logic wr, input logic [5:0] a,
                      input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    check("rd_valid", rd_valid_o, exp_rv);
    check("err", err_o, exp_err);
    check("rd_data", rd_data_o, exp_rd);
    valid_i = v; wr_rd_i = wr; addr_i = a; wr_data_i = d; byte_en_i = be;
    exp_rv = 1'b0; exp_err = 1'b0;
    if (v && ready_o) begin
      if (wr) begin
        for (int b = 0; b < 2; b++) if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
        badmask[a] = badmask[a] & ~be;
      end else begin
        exp_rv  = 1'b1;
        exp_rd  = model[a];
        exp_err = PAR_ON && (badmask[a] != 2'b00);
      end
    end
  endtask

  task automatic op48(input logic wr, input logic [5:0] a, input logic [15:0] d, input logic [1:0] be,
                      input logic erv, input logic [15:0] ed, input logic eerr, input string tag);
    @(negedge clk);
    v48 = 1'b1; wr48 = wr; a48 = a; d48 = d; be48 = be;
    @(negedge clk);
    v48 = 1'b0;
    check({tag, "_rv"}, rv48, erv);
    check({tag, "_err"}, err48, eerr);
    if (erv) check({tag, "_data"}, rd48, ed);
  endtask

  task automatic wait_init(output int n, output int n48);
    n = 0; n48 = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (ready48 && n48 == 0) n48 = n;
      if (ready_o) break;
    end
  endtask

  int n, n48;
  logic [15:0] wd[64];

  initial begin
    model_clear();
    #12;
    check("reset_ready", ready_o, 1'b0);
    check("reset_done", init_done_o, 1'b0);
    check("reset_rv", rd_valid_o, 1'b0);
    check("reset_data", rd_data_o, 16'h0);

    @(negedge clk); rst = 1'b1;
    wait_init(n, n48);
    check("init_cycles", n, 64);
    check("init_done", init_done_o, 1'b1);
    check("init_cycles48", n48, 48);

    // Directed traffic on the 64-word instance.
    step(1, 0, 6'd10, 16'h0, 2'b00);
    step(1, 1, 6'd5, 16'hA5C3, 2'b11);
    step(1, 0, 6'd5, 16'h0, 2'b00);
    step(1, 1, 6'd5, 16'h1234, 2'b01);
    step(1, 0, 6'd5, 16'h0, 2'b00);
    step(1, 1, 6'd5, 16'hFFFF, 2'b00);
    step(1, 0, 6'd5, 16'h0, 2'b00);
    step(1, 1, 6'd7, 16'hBEEF, 2'b11);
    step(1, 0, 6'd7, 16'h0, 2'b00);
    step(0, 0, 6'd0, 16'h0, 2'b00);
    for (int i = 0; i < 64; i++) wd[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) step(1, 1, 6'(i), wd[i], 2'b11);
    for (int i = 0; i < 64; i++) step(1, 0, 6'(i), 16'h0, 2'b00);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 6'($urandom), 16'($urandom), 2'($urandom));
    step(0, 0, 6'd0, 16'h0, 2'b00);

    // Range errors on the 48-word instance.
    op48(1, 6'd5, 16'h1111, 2'b11, 1'b0, 16'h0, 1'b0, "w48_5");
    op48(1, 6'd50, 16'hFFFF, 2'b11, 1'b0, 16'h0, 1'b1, "w48_50");
    op48(0, 6'd50, 16'h0, 2'b00, 1'b1, 16'h0, 1'b1, "r48_50");
    op48(0, 6'd5, 16'h0, 2'b00, 1'b1, 16'h1111, 1'b0, "r48_5");
    op48(0, 6'd2, 16'h0, 2'b00, 1'b1, 16'h0, 1'b0, "r48_2");
    op48(0, 6'd47, 16'h0, 2'b00, 1'b1, 16'h0, 1'b0, "r48_47");
    op48(0, 6'd48, 16'h0, 2'b00, 1'b1, 16'h0, 1'b1, "r48_48");

    // Asynchronous reset while idle, then again 20 cycles into INIT.
    @(posedge clk); #2; rst = 1'b0; #1;
    check("arst_ready", ready_o, 1'b0);
    check("arst_done", init_done_o, 1'b0);
    check("arst_data", rd_data_o, 16'h0);
    @(negedge clk); rst = 1'b1;
    repeat (20) @(posedge clk);
    #2; rst = 1'b0; #1;
    check("arst20_ready", ready_o, 1'b0);
    check("arst20_rv", rd_valid_o, 1'b0);
    check("arst20_err", err_o, 1'b0);
    @(negedge clk); rst = 1'b1;
    model_clear();
    wait_init(n, n48);
    check("reinit_cycles", n, 64);
    for (int i = 0; i < 64; i += 9) step(1, 0, 6'(i), 16'h0, 2'b00);
    step(0, 0, 6'd0, 16'h0, 2'b00);

    // Back-door corruption of one bit; parity builds flag it on read.
    dut.MEM[3][0] = ~dut.MEM[3][0];
    model[3][0]   = ~model[3][0];
    badmask[3]    = 2'b01;
    step(1, 0, 6'd3, 16'h0, 2'b00);
    step(1, 0, 6'd4, 16'h0, 2'b00);
    step(1, 1, 6'd3, 16'h00C3, 2'b01);
    step(1, 0, 6'd3, 16'h0, 2'b00);
    step(0, 0, 6'd0, 16'h0, 2'b00);
    step(0, 0, 6'd0, 16'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
